// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with an integrated TX FIFO, baud divider and configurable frame format.
module uart_tx_fifo #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_W-1:0]             tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int NW = $clog2(DATA_W + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  state_t            state_q, state_d;
  logic [BW-1:0]     baud_q, baud_d;
  logic [NW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d, txd_q, txd_d, busy_q, busy_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0]     level_q, level_d;
  logic              push, pop, bit_end, empty;
  logic [DATA_W-1:0] head;
  assign head       = mem_q[rd_q];
  assign empty      = level_q == '0;
  assign tx_ready   = level_q != LW'(FIFO_DEPTH);
  assign push       = tx_valid && tx_ready;
  assign bit_end    = baud_q == BW'(CLKS_PER_BIT - 1);
  assign txd        = txd_q;
  assign busy       = busy_q;
  assign fifo_level = level_q;
  always_comb begin
    state_d = state_q;
    baud_d  = (state_q == IDLE || bit_end) ? '0 : baud_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    txd_d   = txd_q;
    pop     = 1'b0;
    case (state_q)
      IDLE:  pop = !empty;
      START: if (bit_end) begin
        state_d = DATA;
        txd_d   = shift_q[0];
        shift_d = shift_q >> 1;
      end
      DATA: if (bit_end) begin
        if (bit_q == NW'(DATA_W - 1)) begin
          state_d = (PARITY != 0) ? PAR : STOP;
          txd_d   = (PARITY != 0) ? par_q : 1'b1;
          bit_d   = '0;
        end else begin
          bit_d   = bit_q + 1'b1;
          txd_d   = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      PAR: if (bit_end) begin
        state_d = STOP;
        txd_d   = 1'b1;
      end
      STOP: if (bit_end) begin
        if (bit_q == NW'(STOP_BITS - 1)) begin
          state_d = IDLE;
          txd_d   = 1'b1;
          bit_d   = '0;
          pop     = !empty;
        end else
          bit_d = bit_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // A pop always launches a new frame, from IDLE or straight out of STOP
    if (pop) begin
      state_d = START;
      shift_d = head;
      par_d   = (^head) ^ (PARITY == 2);
      txd_d   = 1'b0;
      baud_d  = '0;
      bit_d   = '0;
    end
    busy_d  = state_d != IDLE;
    wr_d    = wr_q + PW'(push);
    rd_d    = rd_q + PW'(pop);
    level_d = level_q + LW'(push) - LW'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      if (push) mem_q[wr_q] <= tx_data;
    end
  end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with an integrated transmit FIFO, internal baud-rate divider, and configurable frame format: data width, parity and stop bits. Upstream logic pushes words through a valid/ready handshake. The block serialises them LSB-first onto `txd` as back-to-back frames without CPU-paced strobes. It is the next-generation TX path for the board UART link and replaces the external-`txen`, fixed 8N1 transmitter.

## Interface

Parameters:
- `DATA_W`, 8: data bits per frame; legal range 5..9.
- `CLKS_PER_BIT`, 16: `clk` cycles per serial bit; must be ≥ 2.
- `PARITY`, 0: parity mode. 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: number of stop bits; 1 or 2.
- `FIFO_DEPTH`, 4: number of FIFO entries; power of two, ≥ 2.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `tx_data`  in  `DATA_W`  word to transmit.
- `tx_valid`  in  1  `tx_data` is valid this cycle.
- `tx_ready`  out  1  FIFO can accept a word; equals `!full`, driven from registered count.
- `txd`  out  1  serial line, registered; idles high.
- `busy`  out  1  a frame is in progress (FSM state is not IDLE).
- `fifo_level`  out  `$clog2(FIFO_DEPTH)+1`  number of occupied FIFO entries.

## Operation

- **Push:** a word is written on an edge where `tx_valid && tx_ready`. Pushes while full are impossible because `tx_ready` is 0. Push and pop on the same edge leave `fifo_level` unchanged.
- **FSM states:** IDLE, START, DATA, PAR, STOP.
- **IDLE → START:** taken when the FIFO is non-empty. On that edge the head word is popped into the shift register, `txd` is set to 0, and the baud and bit counters clear.
- **Bit timing:** every state holds its `txd` value for exactly `CLKS_PER_BIT` cycles, counted by the baud counter from 0 to `CLKS_PER_BIT-1`.
- **START → DATA:** DATA drives `shift[0]`, then shifts right. After `DATA_W` bits the FSM goes to PAR if `PARITY != 0`, else to STOP.
- **PAR:** `txd` = XOR of the popped word for even parity, or its complement for odd parity. The parity value is computed at pop time and not recomputed from the shifted register.
- **STOP:** `txd` = 1 for `STOP_BITS*CLKS_PER_BIT` cycles.
- **End of STOP:** if the FIFO is non-empty, the FSM goes directly to START with no idle gap, popping as in IDLE. Otherwise it returns to IDLE.
- **Frame length:** `CLKS_PER_BIT*(1 + DATA_W + (PARITY!=0) + STOP_BITS)` cycles.
- **Counter widths:** the baud counter is `$clog2(CLKS_PER_BIT)` bits and the bit counter is `$clog2(DATA_W+1)` bits. Both clear on every state change, with no wrap-around artefacts.
- **FIFO pointers:** `$clog2(FIFO_DEPTH)` bits, wrapping naturally. full = (level == `FIFO_DEPTH`); empty = (level == 0).
- **Reset values:** `txd`=1, `busy`=0, `tx_ready`=1, `fifo_level`=0, state IDLE, all counters 0. FIFO contents are discarded.
- **Reset mid-frame:** on the reset edge `txd` returns to 1 and the frame is truncated, not completed.
- **Data changes:** changes on `tx_data` after acceptance have no effect on the frame.

## Timing

- Push at edge N into an empty FIFO while IDLE:
  - `fifo_level`=1 after N.
  - Pop at edge N+1: `busy`=1, `txd`=0, `fifo_level`=0.
  - First bit period is cycles N+1 .. N+`CLKS_PER_BIT`.
- Latency from the accepting edge to the `txd` falling edge is 1 cycle.
- `busy` falls at the edge ending the last stop bit and only when the FIFO is empty. It stays 1 across back-to-back frames.
- `tx_ready` falls the cycle after the push that fills the FIFO. It rises the cycle after a pop from a full FIFO.

## Test plan

- **Single frame, 8N1:** `CLKS_PER_BIT`=4, 8N1, push 0xA5 → `txd` = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. `busy` is high for exactly 40 cycles, then `fifo_level`=0.
- **Parity:** `PARITY`=1, push 0xA5 → parity bit 0. `PARITY`=2 → parity bit 1. Frame is 44 cycles at `CLKS_PER_BIT`=4.
- **Two stop bits, 7-bit data:** `STOP_BITS`=2, `DATA_W`=7, push 0x41 → stop level high for 8 cycles. Total frame 40 cycles at `CLKS_PER_BIT`=4.
- **FIFO full:** `FIFO_DEPTH`=4, hold `tx_valid` with 6 words 0x01..0x06 → 5 are accepted immediately (one is popped to the shifter) and `tx_ready` drops. The 6th is accepted after the first frame ends. `txd` emits 0x01..0x06 in order with no idle gaps between frames, and `busy` stays high for 6×40 cycles.
- **Simultaneous push and pop:** push on the same edge that a back-to-back pop occurs → `fifo_level` unchanged. The word is transmitted in the correct order.
- **Reset mid-frame:** assert `rst` for 1 cycle mid-DATA with 2 words queued → `txd`=1, `busy`=0, `fifo_level`=0 on the next cycle. No further frames are emitted until a new push.
